// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin command arbiter and sequencer sharing one spiphy
// between REQ requesters. One transaction is in flight at a time. The
// descriptor is latched on grant and issued to the PHY. Completion is awaited
// under a watchdog, and the RX word or a timeout error goes back to the owner.
//
// Handshakes: req_vld_i[i] is held by requester i until req_rdy_o[i] pulses
// for one cycle; the descriptor is taken on that edge. phy_data_vld_o is held
// until an edge where phy_busy_i is low, which is the PHY accept. rsp_vld_o is
// a one-cycle pulse with no backpressure.
module spi_arbiter #(
    parameter  int REQ     = 2,
    parameter  int CS      = 2,
    parameter  int TIMEOUT = 65535,
    localparam int CSW     = $clog2(CS),
    localparam int IDX_W   = $clog2(REQ),
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                 spi_clock_i,
    input  logic                 spi_reset_i,
    input  logic [REQ-1:0]       req_vld_i,
    output logic [REQ-1:0]       req_rdy_o,
    input  logic [32*REQ-1:0]    req_data_i,
    input  logic [CSW*REQ-1:0]   req_cs_id_i,
    input  logic [2*REQ-1:0]     req_rx_bytes_i,
    input  logic [2*REQ-1:0]     req_tx_bytes_i,
    input  logic [2*REQ-1:0]     req_cl_cfg_i,
    input  logic [3*REQ-1:0]     req_clk_div_i,
    output logic [REQ-1:0]       rsp_vld_o,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic [31:0]          phy_data_o,
    output logic [CSW-1:0]       phy_cs_id_o,
    output logic [1:0]           phy_rx_bytes_o,
    output logic [1:0]           phy_tx_bytes_o,
    output logic [1:0]           phy_cl_cfg_o,
    output logic [2:0]           phy_clk_div_o,
    output logic                 phy_data_vld_o,
    input  logic                 phy_busy_i,
    input  logic                 phy_data_vld_i,
    input  logic [31:0]          phy_data_i,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic               timeout_hit;

    logic [31:0]        sel_data;
    logic [CSW-1:0]     sel_cs;
    logic [1:0]         sel_rx;
    logic [1:0]         sel_tx;
    logic [1:0]         sel_cl;
    logic [2:0]         sel_div;

    assign timeout_hit = (cnt == CNT_TO);
    assign dbg_state_o = state;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= REQ; k++) begin
            for (int i = 0; i < REQ; i++) begin
                if (!gnt_found && req_vld_i[i] && (i == (int'(last) + k) % REQ)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Pick out the descriptor fields of the granted requester.
    always_comb begin
        sel_data = '0;
        sel_cs   = '0;
        sel_rx   = '0;
        sel_tx   = '0;
        sel_cl   = '0;
        sel_div  = '0;
        for (int i = 0; i < REQ; i++) begin
            if (IDX_W'(i) == gnt_idx) begin
                sel_data = req_data_i[i*32 +: 32];
                sel_cs   = req_cs_id_i[i*CSW +: CSW];
                sel_rx   = req_rx_bytes_i[i*2 +: 2];
                sel_tx   = req_tx_bytes_i[i*2 +: 2];
                sel_cl   = req_cl_cfg_i[i*2 +: 2];
                sel_div  = req_clk_div_i[i*3 +: 3];
            end
        end
    end

    // State register.
    always_ff @(posedge spi_clock_i or posedge spi_reset_i) begin
        if (spi_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; completion has priority over the watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = ISSUE;
            ISSUE:   if (!phy_busy_i) state_nxt = WAIT;
            WAIT:    if (phy_data_vld_i || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; the grant pulse is suppressed while reset is held.
    always_comb begin
        req_rdy_o      = '0;
        rsp_vld_o      = '0;
        phy_data_vld_o = 1'b0;
        case (state)
            IDLE:    if (gnt_found && !spi_reset_i) req_rdy_o[gnt_idx] = 1'b1;
            ISSUE:   phy_data_vld_o = 1'b1;
            RESP:    rsp_vld_o[owner] = 1'b1;
            default: ;
        endcase
    end

    // Descriptor, owner, round-robin pointer, watchdog and response registers.
    always_ff @(posedge spi_clock_i or posedge spi_reset_i) begin
        if (spi_reset_i) begin
            last           <= IDX_W'(REQ - 1);
            owner          <= '0;
            cnt            <= '0;
            rsp_data_o     <= '0;
            rsp_err_o      <= 1'b0;
            phy_data_o     <= '0;
            phy_cs_id_o    <= '0;
            phy_rx_bytes_o <= '0;
            phy_tx_bytes_o <= '0;
            phy_cl_cfg_o   <= '0;
            phy_clk_div_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        owner          <= gnt_idx;
                        phy_data_o     <= sel_data;
                        phy_cs_id_o    <= sel_cs;
                        phy_rx_bytes_o <= sel_rx;
                        phy_tx_bytes_o <= sel_tx;
                        phy_cl_cfg_o   <= sel_cl;
                        phy_clk_div_o  <= sel_div;
                    end
                end
                ISSUE: begin
                    if (!phy_busy_i) cnt <= '0;
                end
                WAIT: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (phy_data_vld_i) begin
                        rsp_data_o <= phy_data_i;
                        rsp_err_o  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_o <= '0;
                        rsp_err_o  <= 1'b1;
                    end
                end
                RESP: begin
                    last <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench for spi_arbiter (REQ=2, CS=2, TIMEOUT=16).
// Stimulus pushes expected grants, PHY issues and responses into queues; a
// negedge monitor pops and compares them as the DUT presents them.
module tb_spi_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]  req_vld;
    logic [1:0]  req_rdy;
    logic [63:0] req_data;
    logic [1:0]  req_cs;
    logic [3:0]  req_rx;
    logic [3:0]  req_tx;
    logic [3:0]  req_cl;
    logic [5:0]  req_div;
    logic [1:0]  rsp_vld;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] phy_data_o;
    logic        phy_cs_o;
    logic [1:0]  phy_rx_o;
    logic [1:0]  phy_tx_o;
    logic [1:0]  phy_cl_o;
    logic [2:0]  phy_div_o;
    logic        phy_vld_o;
    logic        phy_busy;
    logic        phy_vld;
    logic [31:0] phy_rdata;
    logic [1:0]  dbg_state;

    spi_arbiter #(.REQ(2), .CS(2), .TIMEOUT(16)) dut (
        .spi_clock_i    (clk),
        .spi_reset_i    (rst),
        .req_vld_i      (req_vld),
        .req_rdy_o      (req_rdy),
        .req_data_i     (req_data),
        .req_cs_id_i    (req_cs),
        .req_rx_bytes_i (req_rx),
        .req_tx_bytes_i (req_tx),
        .req_cl_cfg_i   (req_cl),
        .req_clk_div_i  (req_div),
        .rsp_vld_o      (rsp_vld),
        .rsp_data_o     (rsp_data),
        .rsp_err_o      (rsp_err),
        .phy_data_o     (phy_data_o),
        .phy_cs_id_o    (phy_cs_o),
        .phy_rx_bytes_o (phy_rx_o),
        .phy_tx_bytes_o (phy_tx_o),
        .phy_cl_cfg_o   (phy_cl_o),
        .phy_clk_div_o  (phy_div_o),
        .phy_data_vld_o (phy_vld_o),
        .phy_busy_i     (phy_busy),
        .phy_data_vld_i (phy_vld),
        .phy_data_i     (phy_rdata),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] gnt_q[$];
    logic [63:0] iss_q[$];
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_issue(input int r);
        return {22'd0, req_data[r*32 +: 32], req_cs[r], req_rx[r*2 +: 2],
                req_tx[r*2 +: 2], req_cl[r*2 +: 2], req_div[r*3 +: 3]};
    endfunction

    function automatic logic [63:0] mk_rsp(input int wl, input logic [1:0] oh,
                                           input logic e, input logic [31:0] d);
        return {21'd0, 8'(wl), oh, e, d};
    endfunction

    // ---------------- PHY model ----------------
    int          phy_lat  = 0;      // completion on WAIT cycle phy_lat; 0 = never
    logic        phy_echo = 1'b0;   // return ~descriptor word instead of phy_word
    logic [31:0] phy_word = '0;

    initial begin : phy_model
        logic [31:0] desc;
        phy_vld   = 1'b0;
        phy_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && phy_vld_o && !phy_busy && phy_lat != 0) begin
                desc = phy_data_o;
                @(posedge clk);
                for (int k = 1; k < phy_lat; k++) @(posedge clk);
                #1;
                phy_vld   = 1'b1;
                phy_rdata = phy_echo ? ~desc : phy_word;
                @(posedge clk);
                #1;
                phy_vld = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] rdy_prev = '0;
    logic       vld_o_prev = 1'b0;
    logic       phy_vld_prev = 1'b0;
    int         wait_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            wait_cnt = 0;
        end else begin
            if (dbg_state == S_ISSUE) wait_cnt = 0;
            if (dbg_state == S_WAIT) wait_cnt++;
            if (req_rdy != 2'b00) begin
                if (gnt_q.size() == 0) check("grant_unexpected", 64'(req_rdy), 64'd0);
                else check("grant", 64'(req_rdy), gnt_q.pop_front());
            end
            if (phy_vld_o && !vld_o_prev) begin
                check("issue_latency", 64'(rdy_prev != 2'b00), 64'd1);
                if (iss_q.size() == 0) check("issue_unexpected", 64'(phy_vld_o), 64'd0);
                else check("issue", {22'd0, phy_data_o, phy_cs_o, phy_rx_o, phy_tx_o,
                                     phy_cl_o, phy_div_o}, iss_q.pop_front());
            end
            if (rsp_vld != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_vld), 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("rsp", {21'd0, 8'(wait_cnt), rsp_vld, rsp_err, rsp_data}, e);
                    check("rsp_latency", 64'(phy_vld_prev), 64'(!e[32]));
                end
            end
        end
        rdy_prev     = req_rdy;
        vld_o_prev   = phy_vld_o;
        phy_vld_prev = phy_vld;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int budget);
        int n = 0;
        while (gnt_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("grant_wait", 64'(gnt_q.size()), 64'd0);
    endtask

    task automatic wait_all(input int budget);
        int n = 0;
        while ((gnt_q.size() + iss_q.size() + exp_q.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", 64'(gnt_q.size() + iss_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outs();
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_phy_vld", 64'(phy_vld_o), 64'd0);
        check("rst_phy_desc", {22'd0, phy_data_o, phy_cs_o, phy_rx_o, phy_tx_o,
                               phy_cl_o, phy_div_o}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        req_vld  = '0;
        req_data = '0;
        req_cs   = 2'b01;
        req_rx   = 4'b01_10;
        req_tx   = 4'b11_01;
        req_cl   = 4'b10_11;
        req_div  = 6'b010_101;
        phy_busy = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 check_reset_outs();
        tick();
        rst = 1'b0;

        // Single request from req0.
        tick();
        req_data[31:0] = 32'hA5A5_1234;
        phy_echo = 1'b0; phy_word = 32'hDEAD_BEEF; phy_lat = 10;
        gnt_q.push_back(64'(2'b01));
        iss_q.push_back(exp_issue(0));
        exp_q.push_back(mk_rsp(10, 2'b01, 1'b0, 32'hDEAD_BEEF));
        req_vld = 2'b01;
        wait_grants(20);
        req_vld = 2'b00;
        wait_all(40);

        // Both requesters valid through reset: alternate 0,1,0,1.
        tick();
        rst = 1'b1;
        req_vld  = 2'b11;
        req_data = {32'h2222_0001, 32'h1111_0000};
        phy_echo = 1'b1; phy_lat = 3;
        tick();
        check_reset_outs();
        for (int k = 0; k < 2; k++) begin
            gnt_q.push_back(64'(2'b01));
            iss_q.push_back(exp_issue(0));
            exp_q.push_back(mk_rsp(3, 2'b01, 1'b0, 32'hEEEE_FFFF));
            gnt_q.push_back(64'(2'b10));
            iss_q.push_back(exp_issue(1));
            exp_q.push_back(mk_rsp(3, 2'b10, 1'b0, 32'hDDDD_FFFE));
        end
        rst = 1'b0;
        wait_grants(100);
        req_vld = 2'b00;
        wait_all(40);

        // PHY busy for 20 cycles after grant: issue strobe held, no timeout.
        tick();
        req_data[63:32] = 32'h5555_AAAA;
        phy_echo = 1'b1; phy_lat = 2;
        phy_busy = 1'b1;
        gnt_q.push_back(64'(2'b10));
        iss_q.push_back(exp_issue(1));
        exp_q.push_back(mk_rsp(2, 2'b10, 1'b0, 32'hAAAA_5555));
        req_vld = 2'b10;
        wait_grants(20);
        req_vld = 2'b00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("busy_phy_vld", 64'(phy_vld_o), 64'd1);
            check("busy_state", 64'(dbg_state), 64'(S_ISSUE));
        end
        @(posedge clk);
        #1 phy_busy = 1'b0;
        wait_all(40);

        // PHY never completes: error response after 16 WAIT cycles.
        tick();
        req_data[31:0] = 32'h0F0F_F0F0;
        phy_lat = 0;
        gnt_q.push_back(64'(2'b01));
        iss_q.push_back(exp_issue(0));
        exp_q.push_back(mk_rsp(16, 2'b01, 1'b1, 32'h0));
        req_vld = 2'b01;
        wait_grants(20);
        req_vld = 2'b00;
        wait_all(60);

        // Next request after a timeout is served normally.
        tick();
        req_data[63:32] = 32'h3C3C_5A5A;
        phy_echo = 1'b1; phy_lat = 4;
        gnt_q.push_back(64'(2'b10));
        iss_q.push_back(exp_issue(1));
        exp_q.push_back(mk_rsp(4, 2'b10, 1'b0, 32'hC3C3_A5A5));
        req_vld = 2'b10;
        wait_grants(20);
        req_vld = 2'b00;
        wait_all(40);

        // Completion on the timeout cycle: completion wins.
        tick();
        req_data[31:0] = 32'h1234_5678;
        phy_echo = 1'b0; phy_word = 32'h0BAD_F00D; phy_lat = 16;
        gnt_q.push_back(64'(2'b01));
        iss_q.push_back(exp_issue(0));
        exp_q.push_back(mk_rsp(16, 2'b01, 1'b0, 32'h0BAD_F00D));
        req_vld = 2'b01;
        wait_grants(20);
        req_vld = 2'b00;
        wait_all(60);

        // Reset during WAIT: outputs clear at once, no response, req0 first after.
        tick();
        req_data[31:0] = 32'h7777_8888;
        phy_lat = 0;
        gnt_q.push_back(64'(2'b01));
        iss_q.push_back(exp_issue(0));
        req_vld = 2'b01;
        wait_grants(20);
        req_vld = 2'b00;
        n = 0;
        while (dbg_state != S_WAIT && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait", 64'(dbg_state), 64'(S_WAIT));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outs();
        repeat (2) @(posedge clk);
        #1;
        req_data = {32'h0202_0202, 32'h0101_0101};
        phy_echo = 1'b1; phy_lat = 5;
        req_vld  = 2'b11;
        gnt_q.push_back(64'(2'b01));
        iss_q.push_back(exp_issue(0));
        exp_q.push_back(mk_rsp(5, 2'b01, 1'b0, 32'hFEFE_FEFE));
        gnt_q.push_back(64'(2'b10));
        iss_q.push_back(exp_issue(1));
        exp_q.push_back(mk_rsp(5, 2'b10, 1'b0, 32'hFDFD_FDFD));
        rst = 1'b0;
        wait_grants(60);
        req_vld = 2'b00;
        wait_all(40);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin command arbiter and sequencer in front of `spiphy`. It shares one PHY between `REQ` requesters. For each request it:
- accepts and latches one transaction descriptor,
- issues the descriptor to the PHY with the PHY's accept handshake,
- waits for completion, with a watchdog,
- returns the received word to the originating requester.

It sits between the TileLink register front-ends (or DMA) and the PHY, in the `spi_clock_i` domain.

## Interface
- `REQ`, default 2: number of requesters, 2..8.
- `CS`, default 2: chip selects; must match the PHY.
- `TIMEOUT`, default 65535: WAIT-state cycle limit before an error response.

Ports:
- `spi_clock_i`  in  1  sole clock; all logic on its rising edge.
- `spi_reset_i`  in  1  asynchronous, active-high reset.
- `req_vld_i`  in  REQ  request pending, one bit per requester; held until accepted.
- `req_rdy_o`  out  REQ  one-hot, one-cycle accept pulse.
- `req_data_i`  in  32*REQ  TX word; slice i belongs to requester i (same for all `req_*` fields).
- `req_cs_id_i`  in  $clog2(CS)*REQ  chip-select index.
- `req_rx_bytes_i`, `req_tx_bytes_i`  in  2*REQ each  byte counts, passed through to the PHY.
- `req_cl_cfg_i`  in  2*REQ  {CPOL,CPHA}.
- `req_clk_div_i`  in  3*REQ  divider code.
- `rsp_vld_o`  out  REQ  one-hot, one-cycle response pulse; no backpressure.
- `rsp_data_o`  out  32  response word, valid with `rsp_vld_o`.
- `rsp_err_o`  out  1  timeout flag, valid with `rsp_vld_o`.
- `phy_data_o`, `phy_cs_id_o`, `phy_rx_bytes_o`, `phy_tx_bytes_o`, `phy_cl_cfg_o`, `phy_clk_div_o`  out  PHY descriptor fields.
- `phy_data_vld_o`  out  1  issue strobe to the PHY.
- `phy_busy_i`  in  1  PHY busy.
- `phy_data_vld_i`  in  1  PHY completion pulse.
- `phy_data_i`  in  32  PHY RX word.

## Operation
State machine states: IDLE, ISSUE, WAIT, RESP. A round-robin pointer `last` holds the most recently served requester.

- IDLE:
  - Combinational grant: first i with `req_vld_i[i]`=1, searching `last+1, last+2, ...` modulo REQ.
  - `req_rdy_o[g]`=1 for that cycle only.
  - On that edge: latch all fields of g, latch `owner`=g, go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE:
  - `phy_data_vld_o`=1.
  - Accept occurs on the edge where `phy_data_vld_o`=1 and `phy_busy_i`=0.
  - On accept: clear the watchdog counter, go to WAIT.
  - While `phy_busy_i`=1: stay in ISSUE, keep `phy_data_vld_o` high, no timeout.
- WAIT:
  - `phy_data_vld_o`=0; the watchdog counter increments each cycle.
  - `phy_data_vld_i`=1: latch `phy_data_i`, set err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set data=0, err=1, go to RESP.
  - `phy_data_vld_i` and timeout in the same cycle: completion wins, err=0.
- RESP:
  - `rsp_vld_o[owner]`=1 for one cycle, with `rsp_data_o`/`rsp_err_o` valid.
  - On that edge: `last`<=owner, go to IDLE.
- `phy_*` descriptor outputs are registered. They stay stable from ISSUE entry through RESP and change only on a new grant.
- `phy_data_vld_i` outside WAIT is ignored.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- `rsp_data_o`/`rsp_err_o` hold their last values outside RESP; benches check them only with `rsp_vld_o`.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE, `last`=REQ-1, so requester 0 has first priority.
  - `req_rdy_o`=0, `rsp_vld_o`=0, `rsp_data_o`=0, `rsp_err_o`=0.
  - `phy_data_vld_o`=0 and all `phy_*` outputs 0.
- Reset mid-transaction: abort to IDLE, no response is produced, and the pending requester must re-request.
- Latencies, with the PHY idle:
  - Accept at IDLE cycle t; `phy_data_vld_o` high at cycle t+1; PHY accept on the t+1 edge.
  - Completion pulse at WAIT cycle c gives `rsp_vld_o` at cycle c+1.
  - Next grant no earlier than cycle c+2.
- Throughput: one transaction in flight. Minimum gap between `req_rdy_o` pulses is 4 cycles.
- A requester deasserting `req_vld_i` before its grant is legal and is simply skipped.

## Test plan
- REQ=2, only req0 valid, `req_data_i`[0]=0xA5A5_1234, PHY model returns 0xDEAD_BEEF 10 cycles after accept:
  - `req_rdy_o`=01, then `phy_data_vld_o` one cycle later with `phy_data_o`=0xA5A5_1234.
  - `rsp_vld_o`=01, `rsp_data_o`=0xDEAD_BEEF, `rsp_err_o`=0.
- Both requesters held valid continuously from reset:
  - grant order 0,1,0,1.
  - each `rsp_vld_o` bit matches the preceding grant.
- `phy_busy_i` forced high for 20 cycles after grant:
  - `phy_data_vld_o` stays high for all 20 cycles; no timeout; WAIT entered only after busy drops.
- TIMEOUT=16 and PHY never completes:
  - response exactly 16 WAIT cycles after accept, with `rsp_err_o`=1 and `rsp_data_o`=0.
  - the next request is served normally.
- TIMEOUT=16, completion on WAIT cycle 16, coinciding with timeout:
  - err=0 and data equals the PHY word.
- `spi_reset_i` pulsed during WAIT:
  - all outputs 0 asynchronously; no `rsp_vld_o`.
  - after release, req0 wins over req1.
